// File: rtl/f_call_pkg.sv
// ---------------------------------------------------------------------------
// f_call_pkg
// Shared definitions for the caller-side sequencer of function f
// (y = x + a, x and y are ROWS x COLS matrices of WIDTH-bit elements).
//   - matrix geometry and element width
//   - index width for walking the NELEM elements
//   - sequencer state encoding
//   - element offset helpers for the row-major flattened buses
// ---------------------------------------------------------------------------
package f_call_pkg;

    localparam int ROWS   = 10;
    localparam int COLS   = 3;
    localparam int WIDTH  = 64;
    localparam int NELEM  = ROWS * COLS;
    localparam int IDX_W  = $clog2(NELEM);
    localparam int FLAT_W = NELEM * WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        CALL   = 3'd2,
        WAIT   = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    // Linear element index of (r,c) in row-major order.
    function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c);
        return r * COLS + c;
    endfunction

    // Bit offset of linear element idx on a flattened bus.
    function automatic int unsigned elem_off(input int unsigned idx);
        return idx * WIDTH;
    endfunction

endpackage

// File: rtl/f_call_store.sv
// ---------------------------------------------------------------------------
// f_call_store
// NELEM x WIDTH register array used for both the argument matrix and the
// result matrix of the call.
// Ports:
//   clk         clock, rising edge
//   srst        synchronous active-high reset, clears every element
//   i_wr_en     write one element at i_wr_idx with i_wr_data
//   i_load_en   parallel load of all elements from i_load_data (wins over write)
//   i_rd_idx    element selected onto o_rd_data (combinational mux)
//   o_flat      all elements, row-major flattened
// ---------------------------------------------------------------------------
module f_call_store
    import f_call_pkg::*;
(
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic                 i_load_en,
    input  logic [FLAT_W-1:0]    i_load_data,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [WIDTH-1:0]     o_rd_data,
    output logic [FLAT_W-1:0]    o_flat
);

    logic [WIDTH-1:0] r_mem       [NELEM];
    logic [WIDTH-1:0] w_load_elem [NELEM];

    genvar gi;
    generate
        for (gi = 0; gi < NELEM; gi++) begin : g_elem
            assign w_load_elem[gi]                  = i_load_data[elem_off(gi) +: WIDTH];
            assign o_flat[elem_off(gi) +: WIDTH]    = r_mem[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NELEM; i++) begin
            if (srst) begin
                r_mem[i] <= '0;
            end else if (i_load_en) begin
                r_mem[i] <= w_load_elem[i];
            end else if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                r_mem[i] <= i_wr_data;
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/f_caller.sv
// ---------------------------------------------------------------------------
// f_caller
// Initiator side of the call protocol for function f. Collects a and the
// x matrix from a serial valid/ready stream, pulses f_start, waits for
// f_done (bounded by TIMEOUT cycles), captures f_y and streams the result
// elements back out serially.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   in_valid/in_ready/in_data  argument stream: a first, then x row-major
//   out_valid/out_ready/out_data/out_last  result stream, last on element 29
//   f_x, f_a, f_start          arguments and call pulse to the callee
//   f_done, f_y                completion and result from the callee
//   busy                       any state other than IDLE
//   err                        sticky timeout flag, cleared by reset only
// ---------------------------------------------------------------------------
module f_caller
    import f_call_pkg::*;
#(
    parameter int TIMEOUT = 1023
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [FLAT_W-1:0]    f_x,
    output logic [WIDTH-1:0]     f_a,
    output logic                 f_start,
    input  logic                 f_done,
    input  logic [FLAT_W-1:0]    f_y,
    output logic                 busy,
    output logic                 err
);

    localparam int               WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WIDTH-1:0]    r_f_a;
    logic                r_f_start;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_err;

    logic                w_in_ready;
    logic                w_in_acc;
    logic                w_out_acc;
    logic                w_arg_wr;
    logic                w_res_load;
    logic [WIDTH-1:0]    w_arg_rd;
    logic [WIDTH-1:0]    w_res_rd;
    logic [FLAT_W-1:0]   w_res_flat;

    // in_ready is held low while reset is asserted, whatever the state.
    assign w_in_ready = ((r_state == IDLE) || (r_state == LOAD_X)) && !reset;
    assign w_in_acc   = in_valid && w_in_ready;
    assign w_out_acc  = r_out_valid && out_ready;
    assign w_arg_wr   = w_in_acc && (r_state == LOAD_X);
    // done takes priority over a timeout expiring in the same cycle.
    assign w_res_load = (r_state == WAIT) && f_done;

    f_call_store u_arg_store (
        .clk         (clk),
        .srst        (reset),
        .i_wr_en     (w_arg_wr),
        .i_wr_idx    (r_idx),
        .i_wr_data   (in_data),
        .i_load_en   (1'b0),
        .i_load_data ({FLAT_W{1'b0}}),
        .i_rd_idx    (r_idx),
        .o_rd_data   (w_arg_rd),
        .o_flat      (f_x)
    );

    f_call_store u_res_store (
        .clk         (clk),
        .srst        (reset),
        .i_wr_en     (1'b0),
        .i_wr_idx    ({IDX_W{1'b0}}),
        .i_wr_data   ({WIDTH{1'b0}}),
        .i_load_en   (w_res_load),
        .i_load_data (f_y),
        .i_rd_idx    (r_idx),
        .o_rd_data   (w_res_rd),
        .o_flat      (w_res_flat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_f_a       <= '0;
            r_f_start   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_f_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_in_acc) begin
                        r_f_a   <= in_data;
                        r_idx   <= '0;
                        r_state <= LOAD_X;
                    end
                end
                LOAD_X: begin
                    if (w_in_acc) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx     <= '0;
                            r_f_start <= 1'b1;
                            r_state   <= CALL;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                CALL: begin
                    // Any done seen here belongs to no call of ours.
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (f_done) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (LAST_IDX == '0);
                        r_state     <= DRAIN;
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_out_acc) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_out_last <= ((r_idx + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    // Result store is read at the drain index; zero outside DRAIN.
    assign out_data  = r_out_valid ? w_res_rd : '0;
    assign f_a       = r_f_a;
    assign f_start   = r_f_start;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_f_caller.sv
// ---------------------------------------------------------------------------
// tb_f_caller
// Directed bench for f_caller with a small callee model driving f_done/f_y.
// ---------------------------------------------------------------------------
module tb_f_caller;
    import f_call_pkg::*;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_last;
    logic [FLAT_W-1:0]   f_x;
    logic [WIDTH-1:0]    f_a;
    logic                f_start;
    logic                f_done;
    logic [FLAT_W-1:0]   f_y;
    logic                busy;
    logic                err;

    int                  n_checks;
    int                  n_pass;
    int                  start_cnt;
    int                  resp_mode;   // 0 nominal, 1 early+late done, 2 never done
    logic                y_ok;
    logic [63:0]         exp_y [NELEM];

    f_caller #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .f_x       (f_x),
        .f_a       (f_a),
        .f_start   (f_start),
        .f_done    (f_done),
        .f_y       (f_y),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Callee result: y = x + a while y_ok, otherwise recognisable junk.
    always_comb begin
        f_y = '0;
        for (int i = 0; i < NELEM; i++) begin
            f_y[i*WIDTH +: WIDTH] = y_ok ? (f_x[i*WIDTH +: WIDTH] + f_a)
                                         : (64'hDEAD_0000_0000_0000 + 64'(i));
        end
    end

    always @(negedge clk) begin
        if (!reset && f_start) start_cnt++;
    end

    // Callee model.
    initial begin
        f_done = 1'b0;
        y_ok   = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (f_start && !reset) begin
                if (resp_mode == 0) begin
                    y_ok = 1'b1;
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    f_done = 1'b1;
                    @(posedge clk); #1;
                    f_done = 1'b0;
                end else if (resp_mode == 1) begin
                    y_ok   = 1'b0;
                    f_done = 1'b1;              // during the CALL cycle
                    @(posedge clk); #1;
                    f_done = 1'b0;
                    repeat (4) begin
                        @(posedge clk); #1;
                    end
                    y_ok   = 1'b1;
                    f_done = 1'b1;              // 5 cycles after start
                    @(posedge clk); #1;
                    f_done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_f_start", f_start, 0);
        check("rst_f_a", f_a, 0);
        check("rst_f_x0", f_x[63:0], 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
    endtask

    // Sends a then x(i) = xb + i*xm; returns in the cycle after the 31st accept.
    task automatic send_args(input logic [63:0] a, input logic [63:0] xb,
                             input logic [63:0] xm, input int gap);
        logic acc;
        int   bound;
        for (int i = 0; i < NELEM; i++) exp_y[i] = a + xb + xm * 64'(i);
        for (int b = 0; b <= NELEM; b++) begin
            in_valid = 1'b1;
            in_data  = (b == 0) ? a : (xb + xm * 64'(b - 1));
            bound    = 0;
            do begin
                acc = in_ready;
                tick();
                bound++;
            end while (!acc && bound < 100);
            if (!acc) check("in_accept_timeout", 0, 1);
            in_valid = 1'b0;
            if (b < NELEM) repeat (gap) tick();
        end
        $display("send a=%0h xb=%0h xm=%0h gap=%0d done", a, xb, xm, gap);
    endtask

    // Accepts n result elements; bp=1 drives out_ready 1,0,0,1 repeatedly.
    task automatic drain(input int n, input int bp);
        int          k;
        int          cyc;
        logic        stalled;
        logic [63:0] held;
        k = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (k < n && cyc < 600) begin
            out_ready = (bp == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                check("out_data", out_data, exp_y[k]);
                check("out_last", out_last, (k == NELEM - 1));
                $display("out[%0d] = %0h last=%0b", k, out_data, out_last);
                k++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = out_data;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (k < n) check("drain_timeout", 64'(k), 64'(n));
    endtask

    initial begin
        n_checks = 0; n_pass = 0; start_cnt = 0; resp_mode = 0;
        in_data  = '0;
        do_reset();

        // Nominal call with latency checks.
        start_cnt = 0;
        send_args(64'd5, 64'd0, 64'd1, 0);
        check("nom_start_pulse", f_start, 1);
        tick(); tick();
        check("nom_valid_early", out_valid, 0);
        tick();
        check("nom_valid_m1", out_valid, 1);
        check("nom_first_data", out_data, 5);
        drain(NELEM, 0);
        check("nom_in_ready_back", in_ready, 1);
        check("nom_busy_idle", busy, 0);
        check("nom_start_count", 64'(start_cnt), 1);

        // Backpressure.
        send_args(64'd5, 64'd0, 64'd1, 0);
        drain(NELEM, 1);
        check("bp_idle", busy, 0);

        // Input gaps and f_x packing.
        send_args(64'h11, 64'd1000, 64'd1, 3);
        check("gap_start", f_start, 1);
        check("gap_fx_last", f_x[1919:1856], 1029);
        check("gap_fx_first", f_x[63:0], 1000);
        check("gap_fa", f_a, 64'h11);
        tick();
        check("gap_start_pulse_end", f_start, 0);
        drain(NELEM, 0);

        // Early (ignored) and late done.
        resp_mode = 1;
        send_args(64'h1_0000_0000, 64'h77, 64'd3, 0);
        drain(NELEM, 0);
        check("late_idle", busy, 0);

        // Timeout.
        resp_mode = 2;
        send_args(64'd9, 64'd50, 64'd2, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("to_no_valid", out_valid, 0);
        end
        check("to_err_before", err, 0);
        check("to_busy_before", busy, 1);
        tick();
        check("to_err_set", err, 1);
        check("to_idle", busy, 0);
        check("to_in_ready", in_ready, 1);
        check("to_no_valid_after", out_valid, 0);
        repeat (5) tick();
        check("to_err_sticky", err, 1);
        resp_mode = 0;
        send_args(64'd2, 64'd4, 64'd6, 0);
        drain(NELEM, 0);
        check("to_err_sticky_call", err, 1);

        // Reset during DRAIN after element 10.
        do_reset();
        send_args(64'd5, 64'd0, 64'd1, 0);
        repeat (3) tick();
        drain(11, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_fx", f_x[63:0], 0);
        reset = 1'b0;
        tick();
        start_cnt = 0;
        send_args(64'd9, 64'd20, 64'd2, 0);
        drain(NELEM, 0);
        check("fresh_start_count", 64'(start_cnt), 1);
        check("fresh_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
